// File: rtl/trng_pkg.sv
// Shared types and default limits for the TRNG online health test
// (RCT/APT per NIST SP 800-90B).
package trng_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } ht_state_e;

  localparam int unsigned DEFAULT_RCT_CUTOFF = 21;
  localparam int unsigned DEFAULT_APT_WINDOW = 1024;
  localparam int unsigned DEFAULT_APT_CUTOFF = 589;
  localparam int unsigned DEFAULT_MAX_FAILS  = 4;

endpackage

// File: rtl/trng_apt_window.sv
// Adaptive Proportion Test window: reference bit, match count and window
// position. Flags a failure or a window completion for the current sample.
module trng_apt_window
  import trng_pkg::*;
#(
  parameter int unsigned APT_WINDOW = DEFAULT_APT_WINDOW,
  parameter int unsigned APT_CUTOFF = DEFAULT_APT_CUTOFF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample,
  input  logic sample_bit,
  input  logic clear,
  output logic apt_fail,
  output logic win_done
);

  localparam int unsigned APT_W = $clog2(APT_CUTOFF + 1);
  localparam int unsigned WIN_W = $clog2(APT_WINDOW + 1);

  logic             ref_q, ref_d;
  logic [APT_W-1:0] apt_cnt_q, apt_cnt_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;

  // win_cnt == 0 marks "no window open": the next sample becomes the reference
  always_comb begin
    ref_d     = ref_q;
    apt_cnt_d = apt_cnt_q;
    win_cnt_d = win_cnt_q;
    apt_fail  = 1'b0;
    win_done  = 1'b0;
    if (sample) begin
      if (win_cnt_q == '0) begin
        ref_d     = sample_bit;
        apt_cnt_d = APT_W'(1);
        win_cnt_d = WIN_W'(1);
      end else begin
        win_cnt_d = win_cnt_q + 1'b1;
        if (sample_bit == ref_q) begin
          apt_cnt_d = apt_cnt_q + 1'b1;
        end
      end
      apt_fail = (apt_cnt_d == APT_W'(APT_CUTOFF));
      win_done = (win_cnt_d == WIN_W'(APT_WINDOW));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q     <= 1'b0;
      apt_cnt_q <= '0;
      win_cnt_q <= '0;
    end else begin
      ref_q <= ref_d;
      if (clear || win_done) begin
        apt_cnt_q <= '0;
        win_cnt_q <= '0;
      end else begin
        apt_cnt_q <= apt_cnt_d;
        win_cnt_q <= win_cnt_d;
      end
    end
  end

endmodule

// File: rtl/trng_health_test.sv
// Online entropy health test: RCT, APT window, failure escalation and FSM.
// Optional lifetime failure statistics under `TRNG_HT_STATS_EN.
module trng_health_test
  import trng_pkg::*;
#(
  parameter int unsigned RCT_CUTOFF = DEFAULT_RCT_CUTOFF,
  parameter int unsigned APT_WINDOW = DEFAULT_APT_WINDOW,
  parameter int unsigned APT_CUTOFF = DEFAULT_APT_CUTOFF,
  parameter int unsigned MAX_FAILS  = DEFAULT_MAX_FAILS
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             enable_i,
  input  logic                             bit_valid_i,
  input  logic                             bit_i,
  output logic                             error_o,
  output logic                             total_failure_o,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt_o
`ifdef TRNG_HT_STATS_EN
  ,
  output logic [15:0]                      rct_fail_total_o,
  output logic [15:0]                      apt_fail_total_o
`endif
);

  localparam int unsigned RCT_W  = $clog2(RCT_CUTOFF + 1);
  localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);

  ht_state_e         state_q, state_d;
  logic [FAIL_W-1:0] fail_cnt_q, fail_cnt_d;
  logic              error_q, error_d;
  logic              total_q, total_d;
  logic [RCT_W-1:0]  rct_cnt_q, rct_cnt_d;
  logic              rct_bit_q;
  logic              rct_fail, apt_fail, win_done;
  logic              sample, fail, clr;

  // A sample arriving as enable drops is discarded along with the counters
  assign sample = (state_q == RUN) && enable_i && bit_valid_i;
  assign fail   = rct_fail || apt_fail;

  // rct_cnt == 0 means no previous bit to compare against
  always_comb begin
    rct_cnt_d = rct_cnt_q;
    rct_fail  = 1'b0;
    if (sample) begin
      if ((rct_cnt_q == '0) || (bit_i != rct_bit_q)) begin
        rct_cnt_d = RCT_W'(1);
      end else begin
        rct_cnt_d = rct_cnt_q + 1'b1;
      end
      rct_fail = (rct_cnt_d == RCT_W'(RCT_CUTOFF));
    end
  end

  trng_apt_window #(
    .APT_WINDOW (APT_WINDOW),
    .APT_CUTOFF (APT_CUTOFF)
  ) u_apt (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .sample     (sample),
    .sample_bit (bit_i),
    .clear      (clr),
    .apt_fail   (apt_fail),
    .win_done   (win_done)
  );

  always_comb begin
    state_d    = state_q;
    fail_cnt_d = fail_cnt_q;
    error_d    = 1'b0;
    total_d    = total_q;
    clr        = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) state_d = RUN;
      end
      RUN: begin
        if (!enable_i) begin
          state_d = IDLE;
          clr     = 1'b1;
        end else if (fail) begin
          clr        = 1'b1;
          error_d    = 1'b1;
          fail_cnt_d = fail_cnt_q + 1'b1;
          if (fail_cnt_d == FAIL_W'(MAX_FAILS)) begin
            state_d = DEAD;
            total_d = 1'b1;
          end
        end else if (win_done) begin
          fail_cnt_d = '0;
        end
      end
      DEAD: begin
        state_d = DEAD;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      fail_cnt_q <= '0;
      error_q    <= 1'b0;
      total_q    <= 1'b0;
      rct_cnt_q  <= '0;
      rct_bit_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fail_cnt_q <= fail_cnt_d;
      error_q    <= error_d;
      total_q    <= total_d;
      rct_cnt_q  <= clr ? '0 : rct_cnt_d;
      if (sample) rct_bit_q <= bit_i;
    end
  end

  assign error_o         = error_q;
  assign total_failure_o = total_q;
  assign fail_cnt_o      = fail_cnt_q;

`ifdef TRNG_HT_STATS_EN
  logic [15:0] rct_total_q, apt_total_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rct_total_q <= '0;
      apt_total_q <= '0;
    end else begin
      if (rct_fail && (rct_total_q != '1)) rct_total_q <= rct_total_q + 1'b1;
      if (apt_fail && (apt_total_q != '1)) apt_total_q <= apt_total_q + 1'b1;
    end
  end

  assign rct_fail_total_o = rct_total_q;
  assign apt_fail_total_o = apt_total_q;
`endif

endmodule

// File: tb/tb_trng_health_test.sv
// Directed self-checking bench for trng_health_test; the statistics test
// is compiled only with TRNG_HT_STATS_EN defined.
module tb_trng_health_test;
  import trng_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       bit_valid;
  logic       bit_in;
  logic       error;
  logic       total_failure;
  logic [2:0] fail_cnt;
`ifdef TRNG_HT_STATS_EN
  logic [15:0] rct_total;
  logic [15:0] apt_total;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  trng_health_test dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .enable_i        (enable),
    .bit_valid_i     (bit_valid),
    .bit_i           (bit_in),
    .error_o         (error),
    .total_failure_o (total_failure),
    .fail_cnt_o      (fail_cnt)
`ifdef TRNG_HT_STATS_EN
    ,
    .rct_fail_total_o (rct_total),
    .apt_fail_total_o (apt_total)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One valid sample, sampled at the next edge; outputs observed 1 after it
  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic do_reset();
    enable    = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    rst_n     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic start_run();
    enable = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (error !== 1'b0) begin
      $display("FAIL reset_error: got %0b expected 0", error); n_fail++;
    end
    n_checks++;
    if (total_failure !== 1'b0) begin
      $display("FAIL reset_total: got %0b expected 0", total_failure); n_fail++;
    end
    n_checks++;
    if (fail_cnt !== 3'd0) begin
      $display("FAIL reset_fail_cnt: got %0d expected 0", fail_cnt); n_fail++;
    end
  endtask

  // 21 ones: no error through 20, pulse after the 21st, single-cycle
  task automatic test_rct();
    do_reset();
    start_run();
    for (int i = 1; i <= 21; i++) begin
      send_bit(1'b1);
      n_checks++;
      if (error !== (i == 21)) begin
        $display("FAIL rct_error sample %0d: got %0b expected %0b", i, error, (i == 21)); n_fail++;
      end
    end
    n_checks++;
    if (fail_cnt !== 3'd1) begin
      $display("FAIL rct_fail_cnt: got %0d expected 1", fail_cnt); n_fail++;
    end
    tick();
    n_checks++;
    if (error !== 1'b0) begin
      $display("FAIL rct_pulse_width: got %0b expected 0", error); n_fail++;
    end
  endtask

  // Continues from test_rct with fail_cnt=1; a clean window clears it
  task automatic test_apt_clean();
    for (int i = 1; i <= 1024; i++) begin
      send_bit(1'((i - 1) % 2));
      n_checks++;
      if (error !== 1'b0) begin
        $display("FAIL apt_clean_error sample %0d: got %0b expected 0", i, error); n_fail++;
      end
      if (i == 1023) begin
        n_checks++;
        if (fail_cnt !== 3'd1) begin
          $display("FAIL apt_clean_before_end: got %0d expected 1", fail_cnt); n_fail++;
        end
      end
    end
    n_checks++;
    if (fail_cnt !== 3'd0) begin
      $display("FAIL apt_clean_after_end: got %0d expected 0", fail_cnt); n_fail++;
    end
  endtask

  // Pattern 0,0,1 repeated: the 589th zero is sample 883 and must fail
  task automatic test_apt_fail();
    int unsigned zeros;
    int unsigned pulses;
    zeros  = 0;
    pulses = 0;
    do_reset();
    start_run();
    for (int i = 0; zeros < 589; i++) begin
      send_bit(1'((i % 3) == 2));
      if ((i % 3) != 2) zeros++;
      if (error === 1'b1) pulses++;
      n_checks++;
      if (error !== (zeros == 589)) begin
        $display("FAIL apt_fail_error sample %0d: got %0b expected %0b", i + 1, error, (zeros == 589)); n_fail++;
      end
    end
    n_checks++;
    if (pulses != 1) begin
      $display("FAIL apt_fail_pulses: got %0d expected 1", pulses); n_fail++;
    end
    n_checks++;
    if (fail_cnt !== 3'd1) begin
      $display("FAIL apt_fail_cnt: got %0d expected 1", fail_cnt); n_fail++;
    end
    // asynchronous reset while the error pulse is still high
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({error, fail_cnt} !== 4'b0) begin
      $display("FAIL async_reset_run: got err=%0b cnt=%0d expected 0/0", error, fail_cnt); n_fail++;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_total_failure();
    do_reset();
    start_run();
    for (int f = 1; f <= 4; f++) begin
      for (int i = 1; i <= 21; i++) begin
        send_bit(1'b1);
        if (i >= 20) begin
          n_checks++;
          if (error !== (i == 21)) begin
            $display("FAIL tf_error fail %0d sample %0d: got %0b expected %0b", f, i, error, (i == 21)); n_fail++;
          end
        end
      end
      n_checks++;
      if (fail_cnt !== 3'(f)) begin
        $display("FAIL tf_fail_cnt %0d: got %0d expected %0d", f, fail_cnt, f); n_fail++;
      end
      n_checks++;
      if (total_failure !== (f == 4)) begin
        $display("FAIL tf_total %0d: got %0b expected %0b", f, total_failure, (f == 4)); n_fail++;
      end
    end
    // DEAD ignores enable and samples
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    for (int i = 1; i <= 25; i++) begin
      send_bit(1'b1);
      n_checks++;
      if (error !== 1'b0) begin
        $display("FAIL dead_error sample %0d: got %0b expected 0", i, error); n_fail++;
      end
    end
    n_checks++;
    if ({total_failure, fail_cnt} !== {1'b1, 3'd4}) begin
      $display("FAIL dead_state: got total=%0b cnt=%0d expected 1/4", total_failure, fail_cnt); n_fail++;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({error, total_failure, fail_cnt} !== 5'b0) begin
      $display("FAIL async_reset_dead: got total=%0b cnt=%0d expected 0/0", total_failure, fail_cnt); n_fail++;
    end
    rst_n = 1'b1;
  endtask

  // fail_cnt survives disable, counters do not
  task automatic test_reenable();
    do_reset();
    start_run();
    for (int i = 1; i <= 21; i++) send_bit(1'b1);
    for (int i = 1; i <= 10; i++) send_bit(1'b1);
    enable = 1'b0;
    tick();
    tick();
    n_checks++;
    if (fail_cnt !== 3'd1) begin
      $display("FAIL reen_fail_cnt_kept: got %0d expected 1", fail_cnt); n_fail++;
    end
    start_run();
    for (int i = 1; i <= 21; i++) begin
      send_bit(1'b1);
      n_checks++;
      if (error !== (i == 21)) begin
        $display("FAIL reen_error sample %0d: got %0b expected %0b", i, error, (i == 21)); n_fail++;
      end
    end
    n_checks++;
    if (fail_cnt !== 3'd2) begin
      $display("FAIL reen_fail_cnt: got %0d expected 2", fail_cnt); n_fail++;
    end
  endtask

`ifdef TRNG_HT_STATS_EN
  // 284x(0,0,1) gives 568 matches, then 21 zeros hit both cutoffs together
  task automatic test_stats_joint();
    int unsigned pulses;
    pulses = 0;
    do_reset();
    start_run();
    for (int i = 0; i < 852; i++) begin
      send_bit(1'((i % 3) == 2));
      if (error === 1'b1) pulses++;
    end
    for (int i = 1; i <= 21; i++) begin
      send_bit(1'b0);
      if (error === 1'b1) pulses++;
    end
    tick();
    n_checks++;
    if (pulses != 1) begin
      $display("FAIL joint_pulses: got %0d expected 1", pulses); n_fail++;
    end
    n_checks++;
    if (fail_cnt !== 3'd1) begin
      $display("FAIL joint_fail_cnt: got %0d expected 1", fail_cnt); n_fail++;
    end
    n_checks++;
    if ({rct_total, apt_total} !== {16'd1, 16'd1}) begin
      $display("FAIL joint_totals: got rct=%0d apt=%0d expected 1/1", rct_total, apt_total); n_fail++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rct();
    test_apt_clean();
    test_apt_fail();
    test_total_failure();
    test_reenable();
`ifdef TRNG_HT_STATS_EN
    test_stats_joint();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
